// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package arith_pkg;

    // Control states of the serial subtractor.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for the serial subtractor.
//
// Handshake: the requester raises start with a/b valid. The subtractor accepts
// it on a clock edge where it is idle or in its single done cycle. busy is then
// high until the result is ready. done pulses for exactly one cycle with
// diff/borrow_out valid. Those two outputs stay stable until the next done. A
// start seen while busy is ignored, and a/b are don't-care while busy.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // A borrow is generated when b > a. A borrow-in propagates when a == b.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus,
    output sub_state_e          state_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int RW    = WIDTH - 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    // Holds the WIDTH-1 result bits produced so far. The final bit goes straight into diff.
    logic [RW-1:0]    res_q, res_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             fs_d;
    logic             fs_bout;

    full_subtractor_bit u_fs (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (br_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    // State and datapath registers. Reset clears everything, including the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    // Next-state and datapath control. A start is accepted in IDLE or DONE, so operations can run back to back.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    res_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
                // Right shift of {new bit, partial result}, keeping the upper RW bits.
                res_d  = RW'({fs_d, res_q} >> 1);
                br_d   = fs_bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {fs_d, res_q};
                    bout_d  = fs_bout;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = (state_q == SHIFT);
    assign bus.done       = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bout_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;
  import arith_pkg::*;

  localparam int W = 8;
  localparam int DONE_BOUND = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();
  sub_state_e dbg_state;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Scoreboard: {borrow, diff} expected for each accepted start, oldest first.
  logic [W:0] exp_q[$];

  // Reference model: plain integer subtraction, then wrap to W bits.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    int wrapped;
    d = int'(a) - int'(b);
    wrapped = (d + (1 << W)) % (1 << W);
    return {(d < 0), W'(wrapped)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    exp_q.push_back(model(a, b));
    step();
    bus.start = 1'b0;
  endtask

  // Waits for done; lat = cycles after the start edge, or -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 1; i <= DONE_BOUND; i++) begin
      if (bus.busy) busy_cnt++;
      step();
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  function automatic logic [W:0] pop_exp();
    if (exp_q.size() == 0) return '0;
    return exp_q.pop_front();
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    n_vec++;
    if (bus.diff !== '0 || bus.borrow_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_result: diff=%0d borrow=%b, required 0 0", bus.diff, bus.borrow_out);
    end
    n_vec++;
    if (dbg_state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: state=%0d, required IDLE", dbg_state);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{8'd200, 8'd5, 8'h00, 8'hFF, 8'd0};
    logic [W-1:0] tb[5] = '{8'd55, 8'd9, 8'hFF, 8'h01, 8'd0};
    int lat, bc;
    logic [W:0] e;
    for (int i = 0; i < 5; i++) begin
      drive_start(ta[i], tb[i]);
      wait_done(lat, bc);
      e = pop_exp();
      n_vec++;
      if (lat !== 8) begin
        n_err++;
        $display("FAIL dir_latency[%0d]: got %0d cycles, required 8", i, lat);
      end
      n_vec++;
      if (bc !== 8) begin
        n_err++;
        $display("FAIL dir_busy_cycles[%0d]: got %0d, required 8", i, bc);
      end
      n_vec++;
      if (bus.diff !== e[W-1:0] || bus.borrow_out !== e[W]) begin
        n_err++;
        $display("FAIL dir_result[%0d] %0d-%0d: diff=%0d borrow=%b, required %0d %b",
                 i, ta[i], tb[i], bus.diff, bus.borrow_out, e[W-1:0], e[W]);
      end
      step();
      n_vec++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL dir_done_pulse[%0d]: done=%b busy=%b after done, required 0 0",
                 i, bus.done, bus.busy);
      end
    end
    // A fixed constant check on the first case, independent of the model.
    drive_start(8'd200, 8'd55);
    wait_done(lat, bc);
    void'(pop_exp());
    n_vec++;
    if (bus.diff !== 8'd145 || bus.borrow_out !== 1'b0) begin
      n_err++;
      $display("FAIL dir_200_55: diff=%0d borrow=%b, required 145 0", bus.diff, bus.borrow_out);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int n_done = 0;
    logic [W-1:0] got_diff = '0;
    logic got_bout = 1'b0;
    logic [W:0] e;
    drive_start(8'd77, 8'd33);
    repeat (4) begin
      bus.start = 1'b1;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      step();
    end
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.done) begin
        n_done++;
        got_diff = bus.diff;
        got_bout = bus.borrow_out;
      end
    end
    e = pop_exp();
    n_vec++;
    if (n_done !== 1) begin
      n_err++;
      $display("FAIL ignore_done_count: got %0d done pulses, required 1", n_done);
    end
    n_vec++;
    if (got_diff !== e[W-1:0] || got_bout !== e[W]) begin
      n_err++;
      $display("FAIL ignore_result: diff=%0d borrow=%b, required %0d %b",
               got_diff, got_bout, e[W-1:0], e[W]);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [W:0] e1, e2;
    drive_start(8'd40, 8'd90);
    wait_done(lat, bc);
    // In the DONE cycle: request the next operation immediately.
    bus.start = 1'b1;
    bus.a = 8'd100;
    bus.b = 8'd100;
    exp_q.push_back(model(8'd100, 8'd100));
    e1 = pop_exp();
    n_vec++;
    if (bus.diff !== e1[W-1:0] || bus.borrow_out !== e1[W]) begin
      n_err++;
      $display("FAIL b2b_first: diff=%0d borrow=%b, required %0d %b",
               bus.diff, bus.borrow_out, e1[W-1:0], e1[W]);
    end
    step();
    bus.start = 1'b0;
    bus.a = W'($urandom);
    bus.b = W'($urandom);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_bubble: busy=%b done=%b, required 1 0", bus.busy, bus.done);
    end
    n_vec++;
    if (bus.diff !== e1[W-1:0] || bus.borrow_out !== e1[W]) begin
      n_err++;
      $display("FAIL b2b_hold: diff=%0d borrow=%b, required %0d %b",
               bus.diff, bus.borrow_out, e1[W-1:0], e1[W]);
    end
    wait_done(lat, bc);
    e2 = pop_exp();
    n_vec++;
    if (lat !== 8) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d cycles, required 8", lat);
    end
    n_vec++;
    if (bus.diff !== e2[W-1:0] || bus.borrow_out !== e2[W]) begin
      n_err++;
      $display("FAIL b2b_second: diff=%0d borrow=%b, required %0d %b",
               bus.diff, bus.borrow_out, e2[W-1:0], e2[W]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    int lat, bc;
    logic [W:0] e;
    drive_start(8'd123, 8'd45);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== '0 || bus.borrow_out !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: busy=%b done=%b diff=%0d borrow=%b, required 0 0 0 0",
               bus.busy, bus.done, bus.diff, bus.borrow_out);
    end
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.done) n_done++;
    end
    n_vec++;
    if (n_done !== 0) begin
      n_err++;
      $display("FAIL midreset_no_done: got %0d done pulses, required 0", n_done);
    end
    drive_start(8'd10, 8'd3);
    wait_done(lat, bc);
    e = pop_exp();
    n_vec++;
    if (lat !== 8 || bus.diff !== 8'd7 || bus.borrow_out !== e[W]) begin
      n_err++;
      $display("FAIL midreset_restart: lat=%0d diff=%0d borrow=%b, required 8 7 %b",
               lat, bus.diff, bus.borrow_out, e[W]);
    end
    step();
  endtask

  task automatic test_random();
    int lat, bc;
    logic [W-1:0] a, b;
    logic [W:0] e;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      drive_start(a, b);
      wait_done(lat, bc);
      e = pop_exp();
      n_vec++;
      if (lat !== 8 || bus.diff !== e[W-1:0] || bus.borrow_out !== e[W]) begin
        n_err++;
        $display("FAIL rand[%0d] %0d-%0d: lat=%0d diff=%0d borrow=%b, required 8 %0d %b",
                 i, a, b, lat, bus.diff, bus.borrow_out, e[W-1:0], e[W]);
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial unsigned subtractor computing diff = a - b. It is the inverse arithmetic counterpart of the team's combinational adder cells. Processes one bit per clock, LSB first, through a single full-subtractor cell plus a borrow flop. Uses a start/busy/done handshake so it can sit behind a simple controller or a testbench driver.

Parameters:
WIDTH, 8, operand and result width in bits (≥2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when idle or in the done cycle
a  input  WIDTH  minuend, captured on the accepted start edge
b  input  WIDTH  subtrahend, captured on the accepted start edge
busy  output  1  high while a subtraction is in progress
done  output  1  single-cycle pulse: result valid
diff  output  WIDTH  (a - b) mod 2^WIDTH, held stable from done until next accepted start
borrow_out  output  1  final borrow: 1 iff a < b unsigned; held with diff

Behaviour:
- Reset (sync, active-high, wins over everything): state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal shift regs, borrow flop and bit counter = 0.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge k → capture a, b into shift regs, clear the borrow flop, counter=0, go to SHIFT. busy=1 from edge k.
- SHIFT: on each edge, take a_sr[0], b_sr[0] and the borrow flop.
  - d = a0 ^ b0 ^ br
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br)
  - Shift d into the result reg at the MSB, shifting right.
  - Shift a_sr and b_sr right.
  - counter++.
- The WIDTH-th shift occurs at edge k+WIDTH. On that edge: go to DONE, busy=0, done=1, diff=result, borrow_out=br_next.
- Latency: done observed WIDTH cycles after the start edge (8 for the default).
- DONE: lasts exactly one cycle, then goes to IDLE and done=0. start=1 in DONE is accepted exactly as in IDLE, giving back-to-back operation with no bubble.
- start while in SHIFT is ignored. Operands are not re-sampled, and a/b may change freely while busy.
- diff and borrow_out change only at done or reset. They keep the previous result during a new operation.
- The counter is width $clog2(WIDTH+1) and never wraps within an operation.
- Reset mid-SHIFT aborts the operation: no done pulse, outputs cleared, next start behaves normally.

Decomposition:
- Shared package (arith_pkg): state enum {IDLE, SHIFT, DONE}.
- One combinational sub-module, full_subtractor_bit (inputs a, b, bin; outputs d, bout), with logic as in Behaviour. Instantiated once in the serial datapath; reusable for a ripple subtractor later.
- Registers, counter and FSM stay in serial_subtractor.

Test Plan:
- a=200, b=55, pulse start → done exactly 8 cycles later; diff=145, borrow_out=0; busy high for 8 cycles.
- a=5, b=9 → diff=252 (0xFC), borrow_out=1. a=0x00, b=0xFF → diff=0x01, borrow_out=1. a=0xFF, b=0x01 → diff=0xFE, borrow_out=0. a=0, b=0 → 0, 0.
- Start while busy, and a/b changed mid-operation → ignored; the result matches the originally captured operands, with one done pulse only.
- start held high through the DONE cycle with new operands 100-100 → second operation begins with no idle cycle; second done 8 cycles later, diff=0, borrow_out=0. The first result stays visible until then.
- Assert rst during the 3rd SHIFT cycle → next cycle busy=0, done=0, diff=0, borrow_out=0, no done pulse. A following start of 10-3 yields diff=7.
- Randomised sweep, 1000 operand pairs → diff == (a-b)&0xFF and borrow_out == (a<b) every time.
